// File: rtl/sobel_gradient_pipe.sv
// sobel_gradient_pipe: three-stage Sobel gx/gy engine with magnitude, threshold flag and saturating edge counter.
// The edge output is named edge_flag because "edge" is a reserved word.
module sobel_gradient_pipe #(
  parameter int PIX_W = 8,
  parameter int MODE  = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [9*PIX_W-1:0]   window,
  input  logic [PIX_W+2:0]     thresh,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [PIX_W+2:0]     gx,
  output logic [PIX_W+2:0]     gy,
  output logic [PIX_W+2:0]     mag,
  output logic [PIX_W-1:0]     out_pix,
  output logic                 edge_flag,
  input  logic                 cnt_clear,
  output logic [CNT_W-1:0]     edge_cnt
);
  localparam int W = PIX_W + 3;
  function automatic logic signed [PIX_W:0] sub(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction
  function automatic logic signed [W-1:0] sx(input logic signed [PIX_W:0] a);
    return W'(a);
  endfunction
  function automatic logic [W-1:0] abs_w(input logic signed [W-1:0] a);
    return a[W-1] ? W'(-a) : W'(a);
  endfunction
  logic [PIX_W-1:0] p [9];
  for (genvar i = 0; i < 9; i++) begin : g_pix
    assign p[i] = window[i*PIX_W +: PIX_W];
  end
  logic v1, v2, v3, ld1, ld2, ld3;
  logic signed [PIX_W:0] dx0, dx1, dx2, dy0, dy1, dy2;
  logic signed [W-1:0] gx2, gy2, gx3, gy3;
  logic [W-1:0] t1, t2, ax, ay, mag_n, mag3;
  logic [PIX_W-1:0] pix_n, pix3;
  logic edge3;
  // Each stage refills whenever its successor frees a slot in the same cycle.
  assign ld3 = v2 & (!v3 | out_ready);
  assign ld2 = v1 & (!v2 | ld3);
  assign in_ready = !v1 | !v2 | !v3 | out_ready;
  assign ld1 = in_valid & in_ready;
  assign ax = abs_w(gx2);
  assign ay = abs_w(gy2);
  always_comb begin
    mag_n = MODE == 0 ? ax : MODE == 1 ? ay : MODE == 2 ? ax + ay : (ax >= ay ? ax : ay);
    pix_n = |mag_n[W-1:PIX_W] ? {PIX_W{1'b1}} : mag_n[PIX_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= ld1 | (v1 & !ld2);
      v2 <= ld2 | (v2 & !ld3);
      v3 <= ld3 | (v3 & !out_ready);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {dx0, dx1, dx2, dy0, dy1, dy2} <= '0;
      t1 <= '0;
    end else if (ld1) begin
      dx0 <= sub(p[2], p[0]);
      dx1 <= sub(p[5], p[3]);
      dx2 <= sub(p[8], p[6]);
      dy0 <= sub(p[6], p[0]);
      dy1 <= sub(p[7], p[1]);
      dy2 <= sub(p[8], p[2]);
      t1  <= thresh;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      gx2 <= '0;
      gy2 <= '0;
      t2  <= '0;
    end else if (ld2) begin
      gx2 <= sx(dx0) + (sx(dx1) <<< 1) + sx(dx2);
      gy2 <= sx(dy0) + (sx(dy1) <<< 1) + sx(dy2);
      t2  <= t1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      gx3   <= '0;
      gy3   <= '0;
      mag3  <= '0;
      pix3  <= '0;
      edge3 <= 1'b0;
    end else if (ld3) begin
      gx3   <= gx2;
      gy3   <= gy2;
      mag3  <= mag_n;
      pix3  <= pix_n;
      edge3 <= mag_n > t2;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || cnt_clear)
      edge_cnt <= '0;
    else if (v3 && out_ready && edge3 && edge_cnt != {CNT_W{1'b1}})
      edge_cnt <= edge_cnt + 1'b1;
  end
  assign out_valid = v3;
  assign gx        = gx3;
  assign gy        = gy3;
  assign mag       = mag3;
  assign out_pix   = pix3;
  assign edge_flag = edge3;
endmodule

// File: tb/tb_sobel_gradient_pipe.sv
// tb_sobel_gradient_pipe: directed table and sequence checks for sobel_gradient_pipe.
module tb_sobel_gradient_pipe;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 1, cnt_clear = 0;
  logic [71:0] window = '0;
  logic [10:0] thresh = '0;
  logic in_ready, out_valid, edge_flag;
  logic signed [10:0] gx, gy;
  logic [10:0] mag;
  logic [7:0] out_pix;
  logic [3:0] edge_cnt;
  logic [10:0] mm [3], dgx [3], dgy [3];
  logic dir [3], dov [3], de [3];
  logic [7:0] dpx [3];
  logic [3:0] dec [3];
  int n_chk = 0, n_fail = 0;

  sobel_gradient_pipe #(.PIX_W(8), .MODE(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .window(window),
    .thresh(thresh), .out_ready(out_ready), .out_valid(out_valid), .gx(gx), .gy(gy),
    .mag(mag), .out_pix(out_pix), .edge_flag(edge_flag), .cnt_clear(cnt_clear), .edge_cnt(edge_cnt));

  for (genvar k = 0; k < 3; k++) begin : g_mode
    sobel_gradient_pipe #(.PIX_W(8), .MODE(k == 2 ? 3 : k), .CNT_W(4)) m (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(dir[k]), .window(window),
      .thresh(thresh), .out_ready(out_ready), .out_valid(dov[k]), .gx(dgx[k]), .gy(dgy[k]),
      .mag(mm[k]), .out_pix(dpx[k]), .edge_flag(de[k]), .cnt_clear(cnt_clear), .edge_cnt(dec[k]));
  end

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] w;
    int th, gx, gy, mag, pix, e, m0, m1, m3;
  } vec_t;
  vec_t vt [9];

  function automatic logic [71:0] mk(input int p0, p1, p2, p3, p4, p5, p6, p7, p8);
    return {8'(p8), 8'(p7), 8'(p6), 8'(p5), 8'(p4), 8'(p3), 8'(p2), 8'(p1), 8'(p0)};
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send_wait(input logic [71:0] w, input int th, output int lat);
    window = w;
    thresh = 11'(th);
    in_valid = 1;
    step();
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1);
  end

  initial begin
    int lat, exp_cnt, sent, got, pm, pgx;
    bit saw_full, prev_hold, acc_in, seen;
    vt[0] = '{mk(0,0,255,0,0,255,0,0,255), 100, 1020, 0, 1020, 255, 1, 1020, 0, 1020};
    vt[1] = '{mk(0,0,0,0,0,0,255,255,255), 100, 0, 1020, 1020, 255, 1, 0, 1020, 1020};
    vt[2] = '{mk(77,77,77,77,77,77,77,77,77), 100, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[3] = '{mk(0,0,255,0,0,0,0,0,0), 100, 255, -255, 510, 255, 1, 255, 255, 255};
    vt[4] = '{mk(0,0,50,0,0,0,0,0,0), 100, 50, -50, 100, 100, 0, 50, 50, 50};
    vt[5] = '{mk(0,0,50,0,0,0,0,0,0), 99, 50, -50, 100, 100, 1, 50, 50, 50};
    vt[6] = '{mk(255,0,0,255,0,0,255,0,0), 100, -1020, 0, 1020, 255, 1, 1020, 0, 1020};
    vt[7] = '{mk(0,0,0,0,0,10,0,0,0), 0, 20, 0, 20, 20, 1, 20, 0, 20};
    vt[8] = '{mk(30,20,0,0,0,0,0,0,0), 50, -30, -70, 100, 100, 1, 30, 70, 70};

    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_gx", gx, 0);
    chk("rst_gy", gy, 0);
    chk("rst_mag", mag, 0);
    chk("rst_out_pix", out_pix, 0);
    chk("rst_edge", edge_flag, 0);
    chk("rst_edge_cnt", edge_cnt, 0);
    reset = 0;
    step();
    chk("rst_in_ready", in_ready, 1);

    exp_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      send_wait(vt[i].w, vt[i].th, lat);
      chk($sformatf("v%0d_latency", i), lat, 2);
      chk($sformatf("v%0d_gx", i), gx, vt[i].gx);
      chk($sformatf("v%0d_gy", i), gy, vt[i].gy);
      chk($sformatf("v%0d_mag", i), mag, vt[i].mag);
      chk($sformatf("v%0d_out_pix", i), out_pix, vt[i].pix);
      chk($sformatf("v%0d_edge", i), edge_flag, vt[i].e);
      chk($sformatf("v%0d_mag_mode0", i), mm[0], vt[i].m0);
      chk($sformatf("v%0d_mag_mode1", i), mm[1], vt[i].m1);
      chk($sformatf("v%0d_mag_mode3", i), mm[2], vt[i].m3);
      exp_cnt = exp_cnt + vt[i].e;
      step();
      chk($sformatf("v%0d_edge_cnt", i), edge_cnt, exp_cnt);
      chk($sformatf("v%0d_drained", i), out_valid, 0);
    end

    sent = 0; got = 0; saw_full = 0; prev_hold = 0; pm = 0; pgx = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      out_ready = !(c >= 4 && c <= 6);
      in_valid = sent < 8;
      window = mk(0, 0, 0, 0, 0, 5 * (sent + 1), 0, 0, 0);
      thresh = 0;
      #1;
      if (prev_hold) begin
        chk("stall_valid_held", out_valid, 1);
        chk("stall_mag_held", mag, pm);
        chk("stall_gx_held", gx, pgx);
      end
      if (!in_ready) saw_full = 1;
      acc_in = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk($sformatf("stream%0d_mag", got), mag, 10 * (got + 1));
        chk($sformatf("stream%0d_gx", got), gx, 10 * (got + 1));
        got++;
      end
      prev_hold = out_valid && !out_ready;
      pm = int'(mag);
      pgx = int'(gx);
      step();
      if (acc_in) sent++;
    end
    in_valid = 0;
    out_ready = 1;
    chk("stream_sent", sent, 8);
    chk("stream_delivered", got, 8);
    chk("stream_in_ready_fell", saw_full, 1);
    step();
    chk("stream_no_extra", out_valid, 0);

    cnt_clear = 1;
    step();
    cnt_clear = 0;
    chk("clear_edge_cnt", edge_cnt, 0);
    for (int r = 0; r < 2; r++) begin
      repeat (r == 0 ? 15 : 5) begin
        window = vt[0].w;
        thresh = 100;
        in_valid = 1;
        step();
      end
      in_valid = 0;
      repeat (4) step();
      chk($sformatf("sat%0d_edge_cnt", r), edge_cnt, 15);
    end
    send_wait(vt[0].w, 100, lat);
    chk("clr_beat_latency", lat, 2);
    chk("clr_beat_edge", edge_flag, 1);
    cnt_clear = 1;
    step();
    cnt_clear = 0;
    chk("clear_with_transfer", edge_cnt, 0);
    send_wait(vt[0].w, 100, lat);
    step();
    chk("count_after_clear", edge_cnt, 1);

    for (int b = 0; b < 3; b++) begin
      window = vt[b].w;
      thresh = 100;
      in_valid = 1;
      step();
    end
    in_valid = 0;
    chk("pre_reset_valid", out_valid, 1);
    reset = 1;
    step();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_mag", mag, 0);
    chk("midrst_edge_cnt", edge_cnt, 0);
    reset = 0;
    step();
    chk("midrst_in_ready", in_ready, 1);
    seen = 0;
    repeat (6) begin
      if (out_valid) seen = 1;
      step();
    end
    chk("midrst_no_stale", seen, 0);
    send_wait(vt[3].w, 100, lat);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_gx", gx, 255);
    chk("post_rst_gy", gy, -255);
    chk("post_rst_mag", mag, 510);
    chk("post_rst_edge", edge_flag, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
